// File: rtl/mux_arbiter.sv
// Round-robin N:1 mux arbiter with a bounded ownership period.
// Every ownership is followed by at least one idle cycle, which gives the mux a dead cycle to switch.
module mux_arbiter #(
    parameter int N        = 4,
    parameter int W        = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data_in,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] sel,
    output logic [W-1:0]         data_out,
    output logic                 valid_out,
    output logic                 preempt
);

    localparam int SW = $clog2(N);
    // A one-bit counter still works for MAX_HOLD=1 because its limit is then 0.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t        state_reg, state_next;
    logic [SW-1:0] owner_reg, owner_next;
    logic [SW-1:0] ptr_reg,   ptr_next;
    logic [HW-1:0] hold_reg,  hold_next;
    logic          preempt_reg, preempt_next;

    logic [W-1:0]  slice [N];
    logic [N-1:0]  rot_req;
    logic [SW:0]   cand;
    logic [SW-1:0] pick;
    logic          found;
    logic [SW-1:0] owner_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign slice[gi] = data_in[gi*W +: W];
        end
    endgenerate

    // Rotate so that bit 0 of rot_req is the requester at ptr; the first set bit wins.
    always_comb begin
        rot_req = N'({req, req} >> ptr_reg);
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot_req[k]) begin
                found = 1'b1;
                cand  = {1'b0, ptr_reg} + (SW+1)'(k);
                if (cand >= (SW+1)'(N)) begin
                    cand = cand - (SW+1)'(N);
                end
                pick = cand[SW-1:0];
            end
        end
    end

    assign owner_inc = (owner_reg == SW'(N-1)) ? '0 : owner_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            owner_reg   <= '0;
            ptr_reg     <= '0;
            hold_reg    <= '0;
            preempt_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            ptr_reg     <= ptr_next;
            hold_reg    <= hold_next;
            preempt_reg <= preempt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ptr_next     = ptr_reg;
        hold_next    = hold_reg;
        preempt_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = OWN;
                    owner_next = pick;
                    hold_next  = '0;
                end
            end
            OWN: begin
                // A drop of req takes priority over the hold limit, so it never counts as a preemption.
                if (!req[owner_reg]) begin
                    state_next = IDLE;
                    ptr_next   = owner_inc;
                end else if (hold_reg == HW'(MAX_HOLD-1)) begin
                    state_next   = IDLE;
                    ptr_next     = owner_inc;
                    preempt_next = 1'b1;
                end else begin
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        grant     = '0;
        valid_out = 1'b0;
        data_out  = '0;
        if (state_reg == OWN) begin
            grant     = N'(1) << owner_reg;
            valid_out = 1'b1;
            data_out  = slice[owner_reg];
        end
    end

    assign sel     = owner_reg;
    assign preempt = preempt_reg;

endmodule
